// File: rtl/cache_refill_broadcast_server.sv
// -----------------------------------------------------------------------------
// cache_refill_broadcast_server
//
// Responder side of the block-cache refill protocol. Up to N_REQ caches raise
// block-address refill requests. A round-robin arbiter picks one request, and
// the server reads that block from backing memory. It then pulses req_ready to
// the granted cache. At the same time it broadcasts the block address and data
// on a shared bus, so that other caches missing on the same block can fill from
// the broadcast.
//
// Optional feature macro: CACHE_REFILL_LAST_BLOCK_REUSE_EN
//   When defined, the most recently loaded block is remembered. A grant for that
//   same block is answered straight from data_out without a memory read.
//
// Ports:
//   clk, rst              clock, synchronous active-high reset
//   req_valid[N_REQ]      per-cache refill request
//   req_addr              per-cache block address, slot i at [i*OUT_ADDR_WIDTH +: OUT_ADDR_WIDTH]
//   req_ready[N_REQ]      one-cycle accept pulse to the granted cache
//   addr_broadcast        broadcast block address (registered)
//   addr_broadcast_valid  broadcast strobe, one cycle
//   data_out              broadcast block data (registered, held until next load)
//   mem_rd_valid/addr     backing-memory read request, held until mem_rd_ready
//   mem_rd_ready          memory accepts the read request
//   mem_rd_data_valid     read data valid strobe
//   mem_rd_data           read data (one full block)
// -----------------------------------------------------------------------------
module cache_refill_broadcast_server #(
    parameter int N_REQ            = 4,
    parameter int DWIDTH           = 4,
    parameter int BLOCK_WIDTH_BITS = 4,
    parameter int ADDR_IN_WIDTH    = 16,
    localparam int OUT_ADDR_WIDTH  = ADDR_IN_WIDTH - BLOCK_WIDTH_BITS,
    localparam int RAM_WIDTH       = DWIDTH * (2 ** BLOCK_WIDTH_BITS)
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic [N_REQ-1:0]                req_valid,
    input  logic [N_REQ*OUT_ADDR_WIDTH-1:0] req_addr,
    output logic [N_REQ-1:0]                req_ready,
    output logic [OUT_ADDR_WIDTH-1:0]       addr_broadcast,
    output logic                            addr_broadcast_valid,
    output logic [RAM_WIDTH-1:0]            data_out,
    output logic                            mem_rd_valid,
    output logic [OUT_ADDR_WIDTH-1:0]       mem_rd_addr,
    input  logic                            mem_rd_ready,
    input  logic                            mem_rd_data_valid,
    input  logic [RAM_WIDTH-1:0]            mem_rd_data
);

    localparam int IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_ISSUE,
        S_WAIT,
        S_RESPOND
    } state_t;

    state_t                    state;
    logic [IDX_W-1:0]          rr_ptr;
    logic [IDX_W-1:0]          grant_reg;
    logic [OUT_ADDR_WIDTH-1:0] addr_reg;
    logic [IDX_W-1:0]          grant_idx;
    logic                      grant_found;
    logic [IDX_W:0]            cand_sum;
    logic [IDX_W-1:0]          cand_idx;
    logic [OUT_ADDR_WIDTH-1:0] slot_addr [N_REQ];

`ifdef CACHE_REFILL_LAST_BLOCK_REUSE_EN
    logic                      last_valid;
    logic [OUT_ADDR_WIDTH-1:0] last_addr;
`endif

    // Split the flat request-address bus into one entry per cache.
    for (genvar i = 0; i < N_REQ; i++) begin : g_slot
        assign slot_addr[i] = req_addr[i*OUT_ADDR_WIDTH +: OUT_ADDR_WIDTH];
    end

    // The read address is the latched grant address. It stays stable for the
    // whole S_ISSUE handshake.
    assign mem_rd_addr = addr_reg;

    // Round-robin search. Candidates are visited in the order rr_ptr,
    // rr_ptr+1, ... (mod N_REQ), and the first valid one wins. The modulo is
    // done with a single conditional subtract, so N_REQ does not need to be a
    // power of two.
    always_comb begin
        grant_found = 1'b0;
        grant_idx   = '0;
        cand_sum    = '0;
        cand_idx    = '0;
        for (int k = 0; k < N_REQ; k++) begin
            cand_sum = {1'b0, rr_ptr} + (IDX_W+1)'(k);
            if (cand_sum >= (IDX_W+1)'(N_REQ)) begin
                cand_sum = cand_sum - (IDX_W+1)'(N_REQ);
            end
            cand_idx = cand_sum[IDX_W-1:0];
            if (!grant_found && req_valid[cand_idx]) begin
                grant_found = 1'b1;
                grant_idx   = cand_idx;
            end
        end
    end

    // Control FSM. All outputs are registered. The response strobes are set on
    // the transition into S_RESPOND and cleared on the way out, so they last
    // exactly one cycle. data_out and addr_broadcast change only on a response
    // load, so caches can sample them in the cycle after the strobe.
    always_ff @(posedge clk) begin
        if (rst) begin
            state                <= S_IDLE;
            rr_ptr               <= '0;
            grant_reg            <= '0;
            addr_reg             <= '0;
            req_ready            <= '0;
            addr_broadcast       <= '0;
            addr_broadcast_valid <= 1'b0;
            data_out             <= '0;
            mem_rd_valid         <= 1'b0;
`ifdef CACHE_REFILL_LAST_BLOCK_REUSE_EN
            last_valid           <= 1'b0;
            last_addr            <= '0;
`endif
        end else begin
            case (state)
                S_IDLE: begin
                    if (grant_found) begin
                        grant_reg <= grant_idx;
                        addr_reg  <= slot_addr[grant_idx];
`ifdef CACHE_REFILL_LAST_BLOCK_REUSE_EN
                        // data_out already holds this block, so respond
                        // straight away without a memory read.
                        if (last_valid && (slot_addr[grant_idx] == last_addr)) begin
                            req_ready            <= N_REQ'(1) << grant_idx;
                            addr_broadcast       <= slot_addr[grant_idx];
                            addr_broadcast_valid <= 1'b1;
                            state                <= S_RESPOND;
                        end else begin
                            mem_rd_valid <= 1'b1;
                            state        <= S_ISSUE;
                        end
`else
                        mem_rd_valid <= 1'b1;
                        state        <= S_ISSUE;
`endif
                    end
                end
                S_ISSUE: begin
                    if (mem_rd_ready) begin
                        mem_rd_valid <= 1'b0;
                        state        <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (mem_rd_data_valid) begin
                        data_out             <= mem_rd_data;
                        req_ready            <= N_REQ'(1) << grant_reg;
                        addr_broadcast       <= addr_reg;
                        addr_broadcast_valid <= 1'b1;
`ifdef CACHE_REFILL_LAST_BLOCK_REUSE_EN
                        last_valid           <= 1'b1;
                        last_addr            <= addr_reg;
`endif
                        state                <= S_RESPOND;
                    end
                end
                S_RESPOND: begin
                    req_ready            <= '0;
                    addr_broadcast_valid <= 1'b0;
                    rr_ptr               <= (grant_reg == IDX_W'(N_REQ-1)) ? '0
                                                                           : grant_reg + IDX_W'(1);
                    state                <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule
